// File: rtl/wb_if.sv
// MEM-to-writeback bundle: stage controls, MEM results in, register-file write port,
// forwarding tap and status out.
interface wb_if #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 stall;
    logic                 flush;
    logic                 in_valid;
    logic                 in_reg_write;
    logic [4:0]           in_rd;
    logic [1:0]           in_wb_sel;
    logic [2:0]           in_funct3;
    logic [XLEN-1:0]      in_alu_result;
    logic [XLEN-1:0]      in_pc_plus4;
    logic [XLEN-1:0]      in_load_data;
    logic                 we;
    logic [4:0]           rd;
    logic [XLEN-1:0]      wd;
    logic                 fwd_valid;
    logic [4:0]           fwd_rd;
    logic [XLEN-1:0]      fwd_data;
    logic                 load_fault;
    logic [CNT_WIDTH-1:0] retire_count;

    modport master (
        output stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
               in_alu_result, in_pc_plus4, in_load_data,
        input  we, rd, wd, fwd_valid, fwd_rd, fwd_data, load_fault, retire_count
    );

    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
               in_alu_result, in_pc_plus4, in_load_data,
        output we, rd, wd, fwd_valid, fwd_rd, fwd_data, load_fault, retire_count
    );
endinterface

// File: rtl/wb_stage.sv
// RV32I writeback: aligns/extends loads, drives the register-file write port and a retire counter.
// Latency 1 cycle (registered wd); stall holds the stage, flush kills the capture, no backpressure out.
module wb_stage #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 32
) (
    input logic clk,
    input logic rst_n,
    wb_if.slave bus
);
    logic                 valid_q;
    logic                 retired_q;
    logic [4:0]           rd_q;
    logic [XLEN-1:0]      wd_q;
    logic                 reg_write_q;
    logic                 fault_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic [1:0]      off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_val;
    logic            ld_bad;
    logic [XLEN-1:0] wd_next;
    logic            fault_next;
    logic            live;

    assign off  = bus.in_alu_result[1:0];
    assign live = valid_q & ~retired_q;

    always_comb begin
        ld_byte = 8'h00;
        case (off)
            2'd0:    ld_byte = bus.in_load_data[7:0];
            2'd1:    ld_byte = bus.in_load_data[15:8];
            2'd2:    ld_byte = bus.in_load_data[23:16];
            default: ld_byte = bus.in_load_data[31:24];
        endcase
        ld_half = off[1] ? bus.in_load_data[31:16] : bus.in_load_data[15:0];

        ld_val = bus.in_load_data;
        ld_bad = 1'b0;
        case (bus.in_funct3)
            3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001: begin
                ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
                ld_bad = off[0];
            end
            3'b101: begin
                ld_val = {{(XLEN-16){1'b0}}, ld_half};
                ld_bad = off[0];
            end
            3'b010:  ld_bad = (off != 2'd0);
            default: ld_bad = 1'b1;
        endcase

        // wb_sel 11 is reserved and falls back to the ALU result
        wd_next    = bus.in_alu_result;
        fault_next = 1'b0;
        case (bus.in_wb_sel)
            2'b01: begin
                wd_next    = ld_val;
                fault_next = ld_bad;
            end
            2'b10:   wd_next = bus.in_pc_plus4;
            default: wd_next = bus.in_alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            retired_q   <= 1'b0;
            rd_q        <= 5'd0;
            wd_q        <= '0;
            reg_write_q <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // the outgoing instruction counts even when a new one is captured on the same edge
            if (live && !fault_q)
                cnt_q <= cnt_q + CNT_WIDTH'(1);

            if (bus.flush) begin
                valid_q   <= 1'b0;
                retired_q <= retired_q | valid_q;
            end else if (bus.stall) begin
                retired_q <= retired_q | valid_q;
            end else begin
                valid_q     <= bus.in_valid;
                retired_q   <= 1'b0;
                rd_q        <= bus.in_rd;
                wd_q        <= wd_next;
                reg_write_q <= bus.in_reg_write;
                fault_q     <= fault_next;
            end
        end
    end

    assign bus.we           = live & reg_write_q & (rd_q != 5'd0) & ~fault_q;
    assign bus.rd           = rd_q;
    assign bus.wd           = wd_q;
    assign bus.fwd_valid    = bus.we;
    assign bus.fwd_rd       = rd_q;
    assign bus.fwd_data     = wd_q;
    assign bus.load_fault   = live & fault_q;
    assign bus.retire_count = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    logic clk;
    logic rst_n;
    logic rst4_n;

    wb_if #(.XLEN(32), .CNT_WIDTH(32)) bus ();
    wb_if #(.XLEN(32), .CNT_WIDTH(4))  bus4 ();

    wb_stage #(.XLEN(32), .CNT_WIDTH(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    wb_stage #(.XLEN(32), .CNT_WIDTH(4))  u_dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] ld;
        logic        exp_we;
        logic [31:0] exp_wd;
        logic        exp_fault;
        logic        exp_inc;
    } vec_t;

    vec_t vecs[14];
    int total = 0;
    int bad = 0;
    logic [31:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rdn, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] ld);
        bus.in_valid      = v;
        bus.in_reg_write  = rw;
        bus.in_rd         = rdn;
        bus.in_wb_sel     = sel;
        bus.in_funct3     = f3;
        bus.in_alu_result = alu;
        bus.in_pc_plus4   = pc4;
        bus.in_load_data  = ld;
    endtask

    initial begin
        bit hit;
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        bus4.stall         = 1'b0;
        bus4.flush         = 1'b0;
        bus4.in_valid      = 1'b1;
        bus4.in_reg_write  = 1'b1;
        bus4.in_rd         = 5'd1;
        bus4.in_wb_sel     = 2'b00;
        bus4.in_funct3     = 3'b000;
        bus4.in_alu_result = 32'h1;
        bus4.in_pc_plus4   = 32'h0;
        bus4.in_load_data  = 32'h0;

        //            rw  rd     sel    f3      alu           pc4           ld            we  wd            flt inc
        vecs[0]  = '{1'b1, 5'd5,  2'b01, 3'b000, 32'h00001003, 32'h0,        32'h80FF7F01, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 5'd6,  2'b01, 3'b101, 32'h00000002, 32'h0,        32'hBEEF1234, 1'b1, 32'h0000BEEF, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 5'd8,  2'b01, 3'b001, 32'h00000000, 32'h0,        32'h0000F00D, 1'b1, 32'hFFFFF00D, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 5'd9,  2'b01, 3'b010, 32'h00000102, 32'h0,        32'h11223344, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[4]  = '{1'b1, 5'd9,  2'b01, 3'b011, 32'h00000000, 32'h0,        32'h11223344, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[5]  = '{1'b1, 5'd0,  2'b00, 3'b000, 32'h0000DEAD, 32'h0,        32'h0,        1'b0, 32'h0000DEAD, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 5'd1,  2'b10, 3'b000, 32'h00000050, 32'h00000104, 32'h0,        1'b1, 32'h00000104, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 5'd2,  2'b01, 3'b100, 32'h00000002, 32'h0,        32'h80FF7F01, 1'b1, 32'h000000FF, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 5'd3,  2'b01, 3'b000, 32'h00000001, 32'h0,        32'h80FF7F01, 1'b1, 32'h0000007F, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 5'd31, 2'b11, 3'b000, 32'hCAFEF00D, 32'h00000200, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 5'd3,  2'b00, 3'b000, 32'h00000077, 32'h0,        32'h0,        1'b0, 32'h00000077, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 5'd4,  2'b01, 3'b001, 32'h00000001, 32'h0,        32'h12345678, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[12] = '{1'b1, 5'd4,  2'b01, 3'b010, 32'h00000010, 32'h0,        32'h13572468, 1'b1, 32'h13572468, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 5'd4,  2'b01, 3'b110, 32'h00000000, 32'h0,        32'h13572468, 1'b0, 32'h0,        1'b1, 1'b0};

        #12;
        chk("reset we", {31'd0, bus.we}, 32'd0);
        chk("reset rd", {27'd0, bus.rd}, 32'd0);
        chk("reset wd", bus.wd, 32'd0);
        chk("reset fault", {31'd0, bus.load_fault}, 32'd0);
        chk("reset count", bus.retire_count, 32'd0);
        chk("reset fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        exp_cnt = 32'd0;

        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].rw, vecs[i].rd, vecs[i].sel, vecs[i].f3, vecs[i].alu, vecs[i].pc4, vecs[i].ld);
            step();
            chk($sformatf("v%0d we", i), {31'd0, bus.we}, {31'd0, vecs[i].exp_we});
            chk($sformatf("v%0d fwd_valid", i), {31'd0, bus.fwd_valid}, {31'd0, vecs[i].exp_we});
            chk($sformatf("v%0d fault", i), {31'd0, bus.load_fault}, {31'd0, vecs[i].exp_fault});
            if (vecs[i].exp_we)
                chk($sformatf("v%0d rd", i), {27'd0, bus.rd}, {27'd0, vecs[i].rd});
            if (!vecs[i].exp_fault) begin
                chk($sformatf("v%0d wd", i), bus.wd, vecs[i].exp_wd);
                chk($sformatf("v%0d fwd_data", i), bus.fwd_data, vecs[i].exp_wd);
            end
            chk($sformatf("v%0d count pre", i), bus.retire_count, exp_cnt);
            bus.in_valid = 1'b0;
            step();
            exp_cnt = exp_cnt + {31'd0, vecs[i].exp_inc};
            chk($sformatf("v%0d count post", i), bus.retire_count, exp_cnt);
            chk($sformatf("v%0d we post", i), {31'd0, bus.we}, 32'd0);
            chk($sformatf("v%0d fault post", i), {31'd0, bus.load_fault}, 32'd0);
        end

        // stalled instruction writes and counts once; flush while stalled has no further effect
        drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h12345678, 32'h0, 32'h0);
        step();
        chk("stall first we", {31'd0, bus.we}, 32'd1);
        chk("stall first wd", bus.wd, 32'h12345678);
        bus.stall = 1'b1;
        bus.in_alu_result = 32'hFFFFFFFF;
        exp_cnt = exp_cnt + 32'd1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall%0d we", c), {31'd0, bus.we}, 32'd0);
            chk($sformatf("stall%0d wd", c), bus.wd, 32'h12345678);
            chk($sformatf("stall%0d count", c), bus.retire_count, exp_cnt);
        end
        bus.flush = 1'b1;
        step();
        chk("stall flush we", {31'd0, bus.we}, 32'd0);
        chk("stall flush count", bus.retire_count, exp_cnt);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("after flush count", bus.retire_count, exp_cnt);
        chk("after flush we", {31'd0, bus.we}, 32'd0);

        // flush on the capture edge kills the incoming instruction
        drive(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'h00000099, 32'h0, 32'h0);
        bus.flush = 1'b1;
        step();
        chk("cap flush we", {31'd0, bus.we}, 32'd0);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("cap flush count", bus.retire_count, exp_cnt);

        // back-to-back: retire old and capture new on the same edge
        drive(1'b1, 1'b1, 5'd10, 2'b00, 3'b000, 32'h00000011, 32'h0, 32'h0);
        step();
        chk("b2b A wd", bus.wd, 32'h00000011);
        drive(1'b1, 1'b1, 5'd11, 2'b00, 3'b000, 32'h00000022, 32'h0, 32'h0);
        step();
        chk("b2b B we", {31'd0, bus.we}, 32'd1);
        chk("b2b B rd", {27'd0, bus.rd}, 32'd11);
        chk("b2b B wd", bus.wd, 32'h00000022);
        chk("b2b count A", bus.retire_count, exp_cnt + 32'd1);
        bus.in_valid = 1'b0;
        step();
        exp_cnt = exp_cnt + 32'd2;
        chk("b2b count B", bus.retire_count, exp_cnt);

        // asynchronous reset mid-instruction
        drive(1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'h00000055, 32'h0, 32'h0);
        step();
        chk("pre-rst we", {31'd0, bus.we}, 32'd1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst we", {31'd0, bus.we}, 32'd0);
        chk("async rst wd", bus.wd, 32'd0);
        chk("async rst count", bus.retire_count, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post rst count", bus.retire_count, 32'd0);

        // counter wrap on the narrow-counter instance
        rst4_n = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus4.retire_count == 4'hF) begin
                hit = 1'b1;
                break;
            end
        end
        chk("wrap reached max", {31'd0, hit}, 32'd1);
        step();
        chk("wrap to zero", {28'd0, bus4.retire_count}, 32'd0);
        chk("wrap we", {31'd0, bus4.we}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32I pipeline: registers the MEM-stage result, aligns and extends load data, and drives the register file write port (we/rd/wd).
- Also provides a one-cycle forwarding tap for decode bypass and a retired-instruction counter.
- Sits between the data-memory stage and the register file.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_WIDTH, 32, width of retire_count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold the stage register; no new capture.
- flush  in  1  kill the instruction being captured this edge.
- in_valid  in  1  MEM stage presents an instruction.
- in_reg_write  in  1  instruction writes rd.
- in_rd  in  5  destination register.
- in_wb_sel  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- in_funct3  in  3  load type, used when in_wb_sel=01.
- in_alu_result  in  XLEN  ALU result; also the load address (bits [1:0] = byte offset).
- in_pc_plus4  in  XLEN  link value.
- in_load_data  in  XLEN  raw aligned word from data memory, valid with in_valid.
- we  out  1  register-file write enable.
- rd  out  5  register-file write address.
- wd  out  XLEN  register-file write data.
- fwd_valid  out  1  equals we.
- fwd_rd  out  5  equals rd.
- fwd_data  out  XLEN  equals wd.
- load_fault  out  1  held instruction is a misaligned or illegal load.
- retire_count  out  CNT_WIDTH  retired-instruction counter.

Behaviour:
- Reset (rst_n low, async): valid_q=0, retired_q=0, rd_q=0, wd_q=0, reg_write_q=0, fault_q=0, retire_count=0. All outputs therefore read 0.
- Capture on the rising clk edge:
  - flush=1: valid_q<=0, whether or not stall is asserted (flush has priority).
  - else stall=1: all stage registers hold.
  - else: valid_q<=in_valid; rd_q, reg_write_q, wd_q (selected and aligned value) and fault_q are loaded; retired_q<=0.
- Latency: 1 cycle from the input edge to we/wd. Load extraction happens before the stage register, so wd is a registered value.
- Load extraction (off = in_alu_result[1:0]):
  - LB 000: byte[off], sign-extended.
  - LBU 100: byte[off], zero-extended.
  - LH 001: half[off[1]], sign-extended.
  - LHU 101: half[off[1]], zero-extended.
  - LW 010: full word.
- Load fault: LH/LHU with off[0]=1, LW with off≠0, or funct3 ∈ {011, 110, 111} sets fault_q.
- load_fault = valid_q & fault_q & ~retired_q.
- Write: we = valid_q & ~retired_q & reg_write_q & (rd_q≠0) & ~fault_q. rd=rd_q, wd=wd_q. This is a single-cycle pulse per instruction.
- retired_q: set at the edge after any cycle with valid_q & ~retired_q. While stall holds the stage, the instruction therefore writes and counts exactly once. Cleared on new capture.
- retire_count: increments by 1 on each edge where valid_q & ~retired_q & ~fault_q. This includes rd=0 and non-writing instructions. Wraps from all-ones to 0.
- Simultaneous capture and retire on one edge: the old instruction is counted; the new one is loaded with retired_q=0.
- Reset mid-operation: the pending write is dropped; no partial write, no count.

Test Plan:
- LB: alu=0x00001003, load_data=0x80FF7F01, wb_sel=01, rd=5 -> next cycle we=1, rd=5, wd=0xFFFFFF80, retire_count=1.
- LHU off=2, load_data=0xBEEF1234 -> wd=0x0000BEEF. LH off=0 with data 0x0000F00D -> wd=0xFFFFF00D.
- LW alu=0x00000102 -> we=0, load_fault=1 for one cycle, retire_count unchanged. funct3=011 gives the same result.
- Capture ALU op (rd=7, alu=0x12345678), then hold stall=1 for 3 cycles -> we high for exactly one cycle, counter +1 only. Asserting flush while stalled clears valid_q, so no further effects occur.
- rd=0 with reg_write=1 -> we=0, retire_count +1. wb_sel=10 with pc_plus4=0x00000104, rd=1 -> wd=0x00000104.
- Preload retire_count=0xFFFFFFFF via a long run (or force), retire one instruction -> count becomes 0. Drop rst_n mid-stream -> we, wd and retire_count go to 0 immediately, asynchronously.
